// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter with hold limit
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic [3:0] others;
  logic [2:0] idle_hit;
  logic [2:0] grant_hit;

  // Returns {found, index} for the first set candidate starting at start, wrapping mod 4.
  function automatic logic [2:0] rr_search(input logic [3:0] cand, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] pos;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      pos = start + 2'(k);
      if (cand[pos]) begin
        res = {1'b1, pos};
      end
    end
    return res;
  endfunction

  // Search candidates: from ptr when idle, and from holder+1 with the holder masked out,
  // so the holder is always considered last.
  always_comb begin
    others    = req & ~(4'b0001 << idx_q);
    idle_hit  = rr_search(req, ptr_q);
    grant_hit = rr_search(others, idx_q + 2'd1);
  end

  // Next-state and next-output logic for the two-state arbiter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (en && (req != 4'b0000)) begin
          state_d = GRANT;
          idx_d   = idle_hit[1:0];
          ptr_d   = idle_hit[1:0] + 2'd1;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!en) begin
          state_d = IDLE;
          ptr_d   = idx_q + 2'd1;
        end else if (!req[idx_q]) begin
          if (grant_hit[2]) begin
            idx_d  = grant_hit[1:0];
            ptr_d  = grant_hit[1:0] + 2'd1;
            hold_d = 8'd1;
          end else begin
            state_d = IDLE;
            ptr_d   = idx_q + 2'd1;
          end
        end else if (hold_q == HOLD_LIM) begin
          hold_d = 8'd1;
          if (grant_hit[2]) begin
            idx_d = grant_hit[1:0];
            ptr_d = grant_hit[1:0] + 2'd1;
          end
        end else begin
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == GRANT);
    gnt_d  = busy_d ? (4'b0001 << idx_d) : 4'b0000;
  end

  // State and registered outputs; reset clears the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= 8'd0;
      idx_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed self-checking bench for rr_arbiter4
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt8, gnt4;
  logic [1:0] idx8, idx4;
  logic       busy8, busy4;

  int vectors = 0;
  int errors = 0;

  rr_arbiter4 #(.MAX_HOLD(8)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt8), .gnt_idx(idx8), .busy(busy8)
  );

  rr_arbiter4 #(.MAX_HOLD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    req = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt8 !== 4'b0000 || idx8 !== 2'd0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u8: gnt=%b idx=%0d busy=%b, want 0000 0 0", gnt8, idx8, busy8);
    end
    vectors++;
    if (gnt4 !== 4'b0000 || idx4 !== 2'd0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u4: gnt=%b idx=%0d busy=%b, want 0000 0 0", gnt4, idx4, busy4);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1;
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if (gnt8 !== 4'b0001 || idx8 !== 2'd0 || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL single_hold c%0d: gnt=%b idx=%0d busy=%b, want 0001 0 1", c, gnt8, idx8, busy8);
      end
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (gnt8 !== 4'b0000 || idx8 !== 2'd0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL single_release: gnt=%b idx=%0d busy=%b, want 0000 0 0", gnt8, idx8, busy8);
    end
    req = 4'b0001;
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt8 !== 4'b0000 || busy8 !== 1'b0 || gnt4 !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: gnt8=%b busy8=%b gnt4=%b, want 0000 0 0000", gnt8, busy8, gnt4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000;
    en = 1'b0;
  endtask

  task automatic test_rotation();
    logic [1:0] e8, e4;
    do_reset();
    en = 1'b1;
    req = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      tick();
      e8 = 2'(((c - 1) / 8) % 4);
      e4 = 2'(((c - 1) / 4) % 4);
      vectors++;
      if (idx8 !== e8 || gnt8 !== (4'b0001 << e8) || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL rotate8 c%0d: gnt=%b idx=%0d busy=%b, want idx %0d", c, gnt8, idx8, busy8, e8);
      end
      vectors++;
      if (idx4 !== e4 || gnt4 !== (4'b0001 << e4) || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL rotate4 c%0d: gnt=%b idx=%0d busy=%b, want idx %0d", c, gnt4, idx4, busy4, e4);
      end
    end
  endtask

  task automatic test_no_contention();
    do_reset();
    en = 1'b1;
    req = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      vectors++;
      if (gnt4 !== 4'b0010 || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL solo_hold c%0d: gnt=%b busy=%b, want 0010 1", c, gnt4, busy4);
      end
    end
    req = 4'b1010;
    for (int c = 11; c <= 12; c++) begin
      tick();
      vectors++;
      if (gnt4 !== 4'b0010) begin
        errors++;
        $display("FAIL contend_wait c%0d: gnt=%b, want 0010", c, gnt4);
      end
    end
    tick();
    vectors++;
    if (gnt4 !== 4'b1000 || idx4 !== 2'd3) begin
      errors++;
      $display("FAIL contend_expire: gnt=%b idx=%0d, want 1000 3", gnt4, idx4);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1;
    req = 4'b0001;
    tick();
    req = 4'b1010;
    tick();
    vectors++;
    if (gnt8 !== 4'b0010 || idx8 !== 2'd1 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL handover_1: gnt=%b idx=%0d busy=%b, want 0010 1 1", gnt8, idx8, busy8);
    end
    req = 4'b1000;
    tick();
    vectors++;
    if (gnt8 !== 4'b1000 || idx8 !== 2'd3 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL handover_3: gnt=%b idx=%0d busy=%b, want 1000 3 1", gnt8, idx8, busy8);
    end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    en = 1'b1;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    vectors++;
    if (busy8 !== 1'b0 || idx8 !== 2'd1) begin
      errors++;
      $display("FAIL idle_retain: busy=%b idx=%0d, want 0 1", busy8, idx8);
    end
    req = 4'b0011;
    tick();
    vectors++;
    if (gnt8 !== 4'b0001 || idx8 !== 2'd0) begin
      errors++;
      $display("FAIL wrap_search: gnt=%b idx=%0d, want 0001 0", gnt8, idx8);
    end
    req = 4'b0000;
    tick();
    req = 4'b1111;
    tick();
    vectors++;
    if (gnt8 !== 4'b0010 || idx8 !== 2'd1) begin
      errors++;
      $display("FAIL ptr_after_wrap: gnt=%b idx=%0d, want 0010 1", gnt8, idx8);
    end
    do_reset();
    en = 1'b1;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1111;
    tick();
    vectors++;
    if (gnt8 !== 4'b0100 || idx8 !== 2'd2) begin
      errors++;
      $display("FAIL all_from_ptr2: gnt=%b idx=%0d, want 0100 2", gnt8, idx8);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1;
    req = 4'b1111;
    repeat (3) tick();
    en = 1'b0;
    tick();
    vectors++;
    if (gnt8 !== 4'b0000 || busy8 !== 1'b0 || idx8 !== 2'd0) begin
      errors++;
      $display("FAIL en_drop: gnt=%b busy=%b idx=%0d, want 0000 0 0", gnt8, busy8, idx8);
    end
    en = 1'b1;
    tick();
    vectors++;
    if (gnt8 !== 4'b0010 || idx8 !== 2'd1) begin
      errors++;
      $display("FAIL en_restore: gnt=%b idx=%0d, want 0010 1", gnt8, idx8);
    end
    do_reset();
    en = 1'b1;
    req = 4'b1111;
    repeat (8) tick();
    en = 1'b0;
    tick();
    vectors++;
    if (gnt8 !== 4'b0000 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL en_vs_expiry: gnt=%b busy=%b, want 0000 0", gnt8, busy8);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_no_contention();
    test_back_to_back();
    test_ptr_wrap();
    test_en_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
